// File: rtl/conv1d_filter_mac_if.sv
// Stream, result and coefficient-write bundle for conv1d_filter_mac.
// The master side drives samples/coefficients and consumes results.
interface conv1d_filter_mac_if #(
  parameter int BW          = 8,
  parameter int VECTOR_SIZE = 1,
  parameter int NUM_FILTERS = 8
);
  localparam int NW = NUM_FILTERS * 3 * VECTOR_SIZE;
  localparam int AW = $clog2(NW + NUM_FILTERS);

  logic [VECTOR_SIZE*BW-1:0] data_i;
  logic                      valid_i;
  logic                      last_i;
  logic                      ready_o;
  logic [BW-1:0]             data_o;
  logic                      valid_o;
  logic                      last_o;
  logic                      ready_i;
  logic                      wr_en_i;
  logic [AW-1:0]             wr_addr_i;
  logic [BW-1:0]             wr_data_i;
  logic                      err_o;

  modport master (
    output data_i, valid_i, last_i, ready_i,
    output wr_en_i, wr_addr_i, wr_data_i,
    input  ready_o, data_o, valid_o, last_o, err_o
  );

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    input  wr_en_i, wr_addr_i, wr_data_i,
    output ready_o, data_o, valid_o, last_o, err_o
  );
endinterface

// File: rtl/conv1d_filter_mac.sv
// 3-tap sliding-window 1D convolution, one filter per cycle,
// with bias, arithmetic shift and ReLU/saturation on the result.
module conv1d_filter_mac #(
  parameter int BW          = 8,
  parameter int VECTOR_SIZE = 1,
  parameter int FRAME_SIZE  = 50,
  parameter int NUM_FILTERS = 8,
  parameter int SHIFT       = 8
) (
  input logic clk_i,
  input logic rst_i,
  conv1d_filter_mac_if.slave bus
);
  localparam int FILTER_SIZE = 3;
  localparam int ACC_BW = 2*BW + $clog2(3*VECTOR_SIZE+1) + 1;
  localparam int NW  = NUM_FILTERS * FILTER_SIZE * VECTOR_SIZE;
  localparam int NC  = NW + NUM_FILTERS;
  localparam int AW  = $clog2(NC);
  localparam int FW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int BCW = $clog2(FRAME_SIZE+1);
  localparam logic signed [ACC_BW-1:0] MAXA = ACC_BW'((2**(BW-1))-1);
  localparam logic [BW-1:0] MAXO = BW'((2**(BW-1))-1);

  typedef enum logic {S_FILL, S_COMPUTE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [VECTOR_SIZE*BW-1:0] r_win [FILTER_SIZE];
  logic signed [BW-1:0]      r_coef [NC];
  logic [1:0]                r_fill;
  logic [BCW-1:0]            r_beat;
  logic [FW-1:0]             r_f;
  logic                      r_pend_last;
  logic [BW-1:0]             r_data;
  logic                      r_valid;
  logic                      r_last;
  logic                      r_err;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_free;
  logic                      w_issue;
  logic                      w_last_f;
  logic [1:0]                w_fill_nxt;
  logic                      w_full;
  logic [BCW-1:0]            w_beat_nxt;
  logic                      w_frame_end;
  logic                      w_bad;
  logic signed [BW-1:0]      w_smp;
  logic signed [2*BW-1:0]    w_prod;
  logic signed [ACC_BW-1:0]  w_acc;
  logic signed [ACC_BW-1:0]  w_shr;
  logic [BW-1:0]             w_res;

  assign w_ready     = (r_state == S_FILL);
  assign w_accept    = bus.valid_i && w_ready;
  assign w_free      = !r_valid || bus.ready_i;
  assign w_last_f    = (r_f == FW'(NUM_FILTERS-1));
  assign w_fill_nxt  = (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;
  assign w_full      = (w_fill_nxt == 2'd3);
  assign w_beat_nxt  = r_beat + BCW'(1);
  assign w_frame_end = bus.last_i || (w_beat_nxt == BCW'(FRAME_SIZE));
  // Short frames and count-terminated frames are both malformed
  assign w_bad       = w_frame_end && (!w_full || !bus.last_i);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      S_FILL: begin
        if (w_accept && w_full) w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_issue = w_free;
        if (w_free && w_last_f) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    w_smp  = '0;
    w_prod = '0;
    w_acc  = ACC_BW'(r_coef[AW'(NW + int'(r_f))]);
    for (int k = 0; k < FILTER_SIZE; k++) begin
      for (int c = 0; c < VECTOR_SIZE; c++) begin
        w_smp  = r_win[k][c*BW +: BW];
        w_prod = (2*BW)'(w_smp)
               * (2*BW)'(r_coef[AW'((int'(r_f)*FILTER_SIZE+k)*VECTOR_SIZE+c)]);
        w_acc  = w_acc + ACC_BW'(w_prod);
      end
    end
    w_shr = w_acc >>> SHIFT;
    if (w_shr[ACC_BW-1])  w_res = '0;
    else if (w_shr > MAXA) w_res = MAXO;
    else                   w_res = w_shr[BW-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_FILL;
      r_fill      <= '0;
      r_beat      <= '0;
      r_f         <= '0;
      r_pend_last <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < FILTER_SIZE; i++) r_win[i] <= '0;
      for (int i = 0; i < NC; i++) r_coef[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && w_bad;
      if (bus.wr_en_i && (32'(bus.wr_addr_i) < NC))
        r_coef[bus.wr_addr_i] <= bus.wr_data_i;
      if (w_accept) begin
        r_win[0]    <= r_win[1];
        r_win[1]    <= r_win[2];
        r_win[2]    <= bus.data_i;
        r_pend_last <= w_frame_end;
        r_f         <= '0;
        // Window regs keep the taps, so fill can clear right away
        if (w_frame_end) begin
          r_fill <= '0;
          r_beat <= '0;
        end else begin
          r_fill <= w_fill_nxt;
          r_beat <= w_beat_nxt;
        end
      end
      if (w_issue) begin
        r_data  <= w_res;
        r_valid <= 1'b1;
        r_last  <= r_pend_last && w_last_f;
        r_f     <= w_last_f ? '0 : r_f + FW'(1);
      end else if (bus.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.data_o  = r_data;
  assign bus.valid_o = r_valid;
  assign bus.last_o  = r_last;
  assign bus.err_o   = r_err;
endmodule
